// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM for the multicycle RV32I-subset core.
// Steps the datapath one micro-step per clock (fetch, decode, execute,
// memory, write-back) from the IR fields and the ALU flags.
// Optional feature macro: RV_CTRL_ILLEGAL_TRAP_EN. When defined, an illegal
// instruction parks the FSM in HALT and raises the sticky 'illegal' flag.
// When undefined, an illegal instruction is a one-cycle NOP and 'illegal' is 0.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       SignBit,
  output logic       PcEn,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IrWrite,
  output logic       RegWrite,
  output logic [1:0] AluSrcA,
  output logic [1:0] AluSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] RegDataSel,
  output logic [2:0] Immsrc,
  output logic [2:0] AluOp,
  output logic       illegal
);

  typedef enum logic [4:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR,
    S_JUMPPC, S_JUMPWB, S_LUI, S_ILLEGAL, S_HALT
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] alu_f3;
  logic       alu_f3_ok;
  logic       br_ok;
  logic       br_take;

  // State register; reset always restarts at instruction fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // ALU operation from funct3; funct7b5 selects SUB only for register-register ops.
  always_comb begin
    alu_f3    = 3'd0;
    alu_f3_ok = 1'b1;
    case (funct3)
      3'b000:  alu_f3 = (state_q == S_EXECR && funct7b5) ? 3'd1 : 3'd0;
      3'b111:  alu_f3 = 3'd2;
      3'b110:  alu_f3 = 3'd3;
      3'b100:  alu_f3 = 3'd4;
      3'b010:  alu_f3 = 3'd1;
      default: alu_f3_ok = 1'b0;
    endcase
  end

  // Branch condition from the SUB flags of A - B.
  always_comb begin
    br_ok   = 1'b1;
    br_take = 1'b0;
    case (funct3)
      3'b000:  br_take = Zero;
      3'b001:  br_take = ~Zero;
      3'b100:  br_take = SignBit;
      3'b101:  br_take = ~SignBit;
      default: br_ok = 1'b0;
    endcase
  end

  // Next-state and datapath controls decoded from state and IR fields.
  always_comb begin
    state_d    = S_FETCH;
    PcEn       = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IrWrite    = 1'b0;
    RegWrite   = 1'b0;
    AluSrcA    = 2'd0;
    AluSrcB    = 2'd0;
    ResultSrc  = 2'd0;
    RegDataSel = 2'd0;
    Immsrc     = 3'd0;
    AluOp      = 3'd0;
    case (state_q)
      S_FETCH: begin
        IrWrite   = 1'b1;
        AluSrcB   = 2'd2;
        ResultSrc = 2'd2;
        PcEn      = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        AluSrcA = 2'd1;
        AluSrcB = 2'd1;
        Immsrc  = 3'd2;
        case (op)
          7'b0000011, 7'b0100011: state_d = S_MEMADR;
          7'b0110011:             state_d = S_EXECR;
          7'b0010011:             state_d = S_EXECI;
          7'b1100011:             state_d = S_BRANCH;
          7'b1101111:             state_d = S_JAL;
          7'b1100111:             state_d = S_JALR;
          7'b0110111:             state_d = S_LUI;
          default:                state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        AluSrcA = 2'd2;
        AluSrcB = 2'd1;
        Immsrc  = op[5] ? 3'd1 : 3'd0;
        state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        // The data address is held through write-back so the memory port stays quiet.
        AdrSrc    = 1'b1;
        ResultSrc = 2'd1;
        RegWrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        AluSrcA = 2'd2;
        AluSrcB = (state_q == S_EXECI) ? 2'd1 : 2'd0;
        AluOp   = alu_f3;
        state_d = alu_f3_ok ? S_ALUWB : S_ILLEGAL;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        RegDataSel = (funct3 == 3'b010) ? 2'd3 : 2'd1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        AluSrcA = 2'd2;
        AluOp   = 3'd1;
        PcEn    = br_ok & br_take;
        state_d = br_ok ? S_FETCH : S_ILLEGAL;
      end
      S_JAL: begin
        AluSrcA = 2'd1;
        AluSrcB = 2'd1;
        Immsrc  = 3'd3;
        state_d = S_JUMPPC;
      end
      S_JALR: begin
        AluSrcA = 2'd2;
        AluSrcB = 2'd1;
        state_d = S_JUMPPC;
      end
      S_JUMPPC: begin
        PcEn    = 1'b1;
        AluSrcA = 2'd1;
        AluSrcB = 2'd2;
        state_d = S_JUMPWB;
      end
      S_JUMPWB: begin
        RegDataSel = 2'd1;
        RegWrite   = 1'b1;
        state_d    = S_FETCH;
      end
      S_LUI: begin
        Immsrc     = 3'd4;
        RegDataSel = 2'd2;
        RegWrite   = 1'b1;
        state_d    = S_FETCH;
      end
`ifdef RV_CTRL_ILLEGAL_TRAP_EN
      S_ILLEGAL: state_d = S_HALT;
      S_HALT:    state_d = S_HALT;
`else
      S_ILLEGAL: state_d = S_FETCH;
      S_HALT:    state_d = S_FETCH;
`endif
      default:   state_d = S_FETCH;
    endcase
  end

`ifdef RV_CTRL_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  // Sticky flag rises the cycle after HALT is entered and only reset clears it.
  always_comb begin
    illegal_d = illegal_q | (state_q == S_HALT);
  end

  // Illegal-flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) illegal_q <= 1'b0;
    else     illegal_q <= illegal_d;
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench for the multicycle control FSM.
// Each scenario pushes the expected per-cycle control vector for every
// micro-step, then pops and compares one entry per clock.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, Zero, SignBit;
  logic       PcEn, AdrSrc, MemWrite, IrWrite, RegWrite, illegal;
  logic [1:0] AluSrcA, AluSrcB, ResultSrc, RegDataSel;
  logic [2:0] Immsrc, AluOp;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .SignBit(SignBit), .PcEn(PcEn), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IrWrite(IrWrite), .RegWrite(RegWrite),
    .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .ResultSrc(ResultSrc),
    .RegDataSel(RegDataSel), .Immsrc(Immsrc), .AluOp(AluOp), .illegal(illegal)
  );

  always #5 clk = ~clk;

  logic [18:0] obs;
  assign obs = {PcEn, AdrSrc, MemWrite, IrWrite, RegWrite, AluSrcA, AluSrcB,
                ResultSrc, RegDataSel, Immsrc, AluOp};

  typedef struct {
    string       name;
    logic [18:0] vec;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  logic [18:0] V_FETCH, V_DECODE, V_ZERO;

  function automatic logic [18:0] mk(input logic pc, adr, mw, ir, rw,
                                     input logic [1:0] a, b, rs, rds,
                                     input logic [2:0] imm, aop);
    return {pc, adr, mw, ir, rw, a, b, rs, rds, imm, aop};
  endfunction

  task automatic push(input string n, input logic [18:0] v);
    exp_t e;
    e.name = n;
    e.vec  = v;
    sb.push_back(e);
  endtask

  task automatic set_inst(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                          input logic z, input logic s);
    op = o; funct3 = f3; funct7b5 = f7; Zero = z; SignBit = s;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    set_inst(7'b0000000, 3'b000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (obs !== V_FETCH) $display("[TB] FAIL reset_outputs: got %h want %h", obs, V_FETCH);
    else passed++;
    checks++;
    if (illegal !== 1'b0) $display("[TB] FAIL reset_illegal: got %b want 0", illegal);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_load;
    set_inst(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0);
    push("lw_fetch", V_FETCH);
    push("lw_decode", V_DECODE);
    push("lw_memadr", mk(0,0,0,0,0, 2'd2,2'd1,2'd0,2'd0, 3'd0,3'd0));
    push("lw_memread", mk(0,1,0,0,0, 2'd0,2'd0,2'd0,2'd0, 3'd0,3'd0));
    push("lw_memwb", mk(0,1,0,0,1, 2'd0,2'd0,2'd1,2'd0, 3'd0,3'd0));
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      #1;
      checks++;
      if (obs !== e.vec) $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.vec);
      else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_store;
    set_inst(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0);
    push("sw_fetch", V_FETCH);
    push("sw_decode", V_DECODE);
    push("sw_memadr", mk(0,0,0,0,0, 2'd2,2'd1,2'd0,2'd0, 3'd1,3'd0));
    push("sw_memwrite", mk(0,1,1,0,0, 2'd0,2'd0,2'd0,2'd0, 3'd0,3'd0));
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      #1;
      checks++;
      if (obs !== e.vec) $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.vec);
      else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_alu_ops;
    logic [6:0] ops  [6] = '{7'b0110011, 7'b0110011, 7'b0110011, 7'b0010011, 7'b0010011, 7'b0010011};
    logic [2:0] f3s  [6] = '{3'b000, 3'b010, 3'b110, 3'b000, 3'b100, 3'b111};
    logic       f7s  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [2:0] aops [6] = '{3'd1, 3'd1, 3'd3, 3'd0, 3'd4, 3'd2};
    logic [1:0] rdss [6] = '{2'd1, 2'd3, 2'd1, 2'd1, 2'd1, 2'd1};
    for (int i = 0; i < 6; i++) begin
      logic is_i;
      is_i = (ops[i] == 7'b0010011);
      set_inst(ops[i], f3s[i], f7s[i], 1'b0, 1'b0);
      push($sformatf("alu%0d_fetch", i), V_FETCH);
      push($sformatf("alu%0d_decode", i), V_DECODE);
      push($sformatf("alu%0d_exec", i),
           mk(0,0,0,0,0, 2'd2, is_i ? 2'd1 : 2'd0, 2'd0, 2'd0, 3'd0, aops[i]));
      push($sformatf("alu%0d_wb", i), mk(0,0,0,0,1, 2'd0,2'd0,2'd0, rdss[i], 3'd0,3'd0));
      while (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        #1;
        checks++;
        if (obs !== e.vec) $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.vec);
        else passed++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_branch;
    logic [2:0] f3s [5] = '{3'b000, 3'b000, 3'b001, 3'b100, 3'b101};
    logic       zs  [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       ss  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic       tk  [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      set_inst(7'b1100011, f3s[i], 1'b0, zs[i], ss[i]);
      push($sformatf("br%0d_fetch", i), V_FETCH);
      push($sformatf("br%0d_decode", i), V_DECODE);
      push($sformatf("br%0d_branch", i), mk(tk[i],0,0,0,0, 2'd2,2'd0,2'd0,2'd0, 3'd0,3'd1));
      while (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        #1;
        checks++;
        if (obs !== e.vec) $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.vec);
        else passed++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_jumps;
    set_inst(7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0);
    push("jal_fetch", V_FETCH);
    push("jal_decode", V_DECODE);
    push("jal_target", mk(0,0,0,0,0, 2'd1,2'd1,2'd0,2'd0, 3'd3,3'd0));
    push("jal_jumppc", mk(1,0,0,0,0, 2'd1,2'd2,2'd0,2'd0, 3'd0,3'd0));
    push("jal_jumpwb", mk(0,0,0,0,1, 2'd0,2'd0,2'd0,2'd1, 3'd0,3'd0));
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      #1;
      checks++;
      if (obs !== e.vec) $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.vec);
      else passed++;
      @(negedge clk);
    end
    set_inst(7'b1100111, 3'b000, 1'b0, 1'b0, 1'b0);
    push("jalr_fetch", V_FETCH);
    push("jalr_decode", V_DECODE);
    push("jalr_target", mk(0,0,0,0,0, 2'd2,2'd1,2'd0,2'd0, 3'd0,3'd0));
    push("jalr_jumppc", mk(1,0,0,0,0, 2'd1,2'd2,2'd0,2'd0, 3'd0,3'd0));
    push("jalr_jumpwb", mk(0,0,0,0,1, 2'd0,2'd0,2'd0,2'd1, 3'd0,3'd0));
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      #1;
      checks++;
      if (obs !== e.vec) $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.vec);
      else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_lui;
    set_inst(7'b0110111, 3'b101, 1'b1, 1'b0, 1'b0);
    push("lui_fetch", V_FETCH);
    push("lui_decode", V_DECODE);
    push("lui_wb", mk(0,0,0,0,1, 2'd0,2'd0,2'd0,2'd2, 3'd4,3'd0));
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      #1;
      checks++;
      if (obs !== e.vec) $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.vec);
      else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_illegal_funct3;
    set_inst(7'b0110011, 3'b001, 1'b0, 1'b0, 1'b0);
    push("badf3_fetch", V_FETCH);
    push("badf3_decode", V_DECODE);
    push("badf3_execr", mk(0,0,0,0,0, 2'd2,2'd0,2'd0,2'd0, 3'd0,3'd0));
    push("badf3_illegal", V_ZERO);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      #1;
      checks++;
      if (obs !== e.vec) $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.vec);
      else passed++;
      @(negedge clk);
    end
`ifdef RV_CTRL_ILLEGAL_TRAP_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`endif
  endtask

  task automatic test_illegal_op;
    set_inst(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0);
    push("badop_fetch", V_FETCH);
    push("badop_decode", V_DECODE);
    push("badop_illegal", V_ZERO);
`ifdef RV_CTRL_ILLEGAL_TRAP_EN
    for (int i = 0; i < 4; i++) push($sformatf("badop_halt%0d", i), V_ZERO);
`endif
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      #1;
      checks++;
      if (obs !== e.vec) $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.vec);
      else passed++;
      @(negedge clk);
    end
`ifdef RV_CTRL_ILLEGAL_TRAP_EN
    #1;
    checks++;
    if (illegal !== 1'b1) $display("[TB] FAIL halt_illegal: got %b want 1", illegal);
    else passed++;
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== V_FETCH) $display("[TB] FAIL halt_rst_outputs: got %h want %h", obs, V_FETCH);
    else passed++;
    checks++;
    if (illegal !== 1'b0) $display("[TB] FAIL halt_rst_illegal: got %b want 0", illegal);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
`else
    #1;
    checks++;
    if (illegal !== 1'b0) $display("[TB] FAIL nop_illegal: got %b want 0", illegal);
    else passed++;
`endif
  endtask

  task automatic test_reset_mid;
    set_inst(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0);
    push("mid_fetch", V_FETCH);
    push("mid_decode", V_DECODE);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      #1;
      checks++;
      if (obs !== e.vec) $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.vec);
      else passed++;
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== V_FETCH) $display("[TB] FAIL mid_rst_async: got %h want %h", obs, V_FETCH);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    push("after_rst_fetch", V_FETCH);
    push("after_rst_decode", V_DECODE);
    push("after_rst_memadr", mk(0,0,0,0,0, 2'd2,2'd1,2'd0,2'd0, 3'd0,3'd0));
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      #1;
      checks++;
      if (obs !== e.vec) $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.vec);
      else passed++;
      @(negedge clk);
    end
  endtask

  initial begin
    V_FETCH  = mk(1,0,0,1,0, 2'd0,2'd2,2'd2,2'd0, 3'd0,3'd0);
    V_DECODE = mk(0,0,0,0,0, 2'd1,2'd1,2'd0,2'd0, 3'd2,3'd0);
    V_ZERO   = '0;
    test_reset();
    test_load();
    test_store();
    test_alu_ops();
    test_branch();
    test_jumps();
    test_lui();
    test_illegal_funct3();
    test_illegal_op();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
